// File: rtl/mire_gen.sv
`default_nettype none
// ============================================================================
//  Module   : mire_gen
//  Purpose  : Wishbone-master test-pattern generator. Paints a full
//             HDISP x VDISP RGB565 frame (grid, colour bars, checker or
//             solid fill) into a framebuffer, yielding the bus between
//             bursts and optionally repeating frame after frame.
//  Revision : 1.0  initial release
// ============================================================================
module mire_gen #(
  parameter int                vga_HDISP = 640,
  parameter int                vga_VDISP = 480,
  parameter int                DATA_W    = 16,
  parameter int                ADR_W     = 32,
  parameter logic [ADR_W-1:0]  BASE_ADDR = '0,
  parameter int                GRID_LOG2 = 4,
  parameter int                BURST_LEN = 64,
  parameter int                YIELD_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                continuous,
  input  logic [1:0]          mode,
  input  logic [15:0]         fill_color,
  output logic                busy,
  output logic                frame_done,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic [ADR_W-1:0]    wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic                wb_ack_i
);

  // Pixels carried by one bus word (1 for 16-bit, 2 for 32-bit).
  localparam int PPW   = DATA_W / 16;
  // Counters are widened so that bit GRID_LOG2 always exists for the checker.
  localparam int X_W   = ($clog2(vga_HDISP) > GRID_LOG2) ? $clog2(vga_HDISP) : GRID_LOG2 + 1;
  localparam int Y_W   = ($clog2(vga_VDISP + 1) > GRID_LOG2) ? $clog2(vga_VDISP + 1) : GRID_LOG2 + 1;
  localparam int BAR_W = vga_HDISP / 8;
  localparam int BP_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int BS_W  = 3 + BP_W;
  localparam int BC_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int YC_W  = (YIELD_CYC > 1) ? $clog2(YIELD_CYC) : 1;

  localparam logic [X_W-1:0]   X_LAST     = X_W'(vga_HDISP - PPW);
  localparam logic [X_W-1:0]   X_STEP     = X_W'(PPW);
  localparam logic [Y_W-1:0]   Y_LAST     = Y_W'(vga_VDISP - 1);
  localparam logic [ADR_W-1:0] ADR_STEP   = ADR_W'(DATA_W / 8);
  localparam logic [BP_W-1:0]  BAR_LAST   = BP_W'((BAR_W > 0) ? BAR_W - 1 : 0);
  // With fewer than 8 pixels per line every bar is empty and bar 7 applies.
  localparam logic [2:0]       BAR_FIRST  = (BAR_W > 0) ? 3'd0 : 3'd7;
  localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(BURST_LEN - 1);
  localparam logic [YC_W-1:0]  YIELD_LAST = YC_W'(YIELD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_BURST = 3'd2,
    ST_YIELD = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  logic [1:0]        r_mode;
  logic [15:0]       r_fill;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [ADR_W-1:0]  r_adr;
  logic [2:0]        r_bar_idx;
  logic [BP_W-1:0]   r_bar_pos;
  logic [BC_W-1:0]   r_burst;
  logic [YC_W-1:0]   r_yield;

  logic [DATA_W-1:0] w_word;
  logic [BS_W-1:0]   w_bar_adv;
  logic              w_last;

  // Colour of one pixel given its coordinates and its colour-bar index.
  function automatic logic [15:0] pix_color(
    input logic [1:0]     m,
    input logic [15:0]    fill,
    input logic [X_W-1:0] px,
    input logic [Y_W-1:0] py,
    input logic [2:0]     bar
  );
    logic [15:0] c;
    c = 16'h0000;
    case (m)
      2'd0: c = ((px[GRID_LOG2-1:0] == '0) || (py[GRID_LOG2-1:0] == '0)) ? 16'hFFFF : 16'h0000;
      2'd1: begin
        case (bar)
          3'd0:    c = 16'hFFFF;
          3'd1:    c = 16'hFFE0;
          3'd2:    c = 16'h07FF;
          3'd3:    c = 16'h07E0;
          3'd4:    c = 16'hF81F;
          3'd5:    c = 16'hF800;
          3'd6:    c = 16'h001F;
          default: c = 16'h0000;
        endcase
      end
      2'd2:    c = (px[GRID_LOG2] ^ py[GRID_LOG2]) ? 16'hFFFF : 16'h0000;
      default: c = fill;
    endcase
    return c;
  endfunction

  // Advance the {bar index, position-in-bar} tracker by one pixel; the
  // last bar absorbs any leftover pixels at the right edge.
  function automatic logic [BS_W-1:0] bar_step(input logic [BS_W-1:0] b);
    logic [2:0]      idx;
    logic [BP_W-1:0] pos;
    {idx, pos} = b;
    if (idx != 3'd7) begin
      if (pos == BAR_LAST) begin
        idx = idx + 3'd1;
        pos = '0;
      end else begin
        pos = pos + BP_W'(1);
      end
    end
    return {idx, pos};
  endfunction

  assign w_last = (r_x == X_LAST) && (r_y == Y_LAST);

  generate
    if (DATA_W == 32) begin : g_word32
      logic [X_W-1:0]  w_x_odd;
      logic [BS_W-1:0] w_bar_odd;
      assign w_x_odd   = r_x + X_W'(1);
      assign w_bar_odd = bar_step({r_bar_idx, r_bar_pos});
      assign w_bar_adv = bar_step(w_bar_odd);
      assign w_word    = {pix_color(r_mode, r_fill, w_x_odd, r_y, w_bar_odd[BS_W-1 -: 3]),
                          pix_color(r_mode, r_fill, r_x, r_y, r_bar_idx)};
    end else begin : g_word16
      assign w_bar_adv = bar_step({r_bar_idx, r_bar_pos});
      assign w_word    = pix_color(r_mode, r_fill, r_x, r_y, r_bar_idx);
    end
  endgenerate

  // Frame sequencer: walks the raster, presents each word, and handles
  // the post-ack bubble, fair-play yield and frame completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mode     <= 2'd0;
      r_fill     <= 16'h0000;
      r_x        <= '0;
      r_y        <= '0;
      r_adr      <= BASE_ADDR;
      r_bar_idx  <= BAR_FIRST;
      r_bar_pos  <= '0;
      r_burst    <= '0;
      r_yield    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_sel_o   <= '0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode    <= mode;
            r_fill    <= fill_color;
            r_x       <= '0;
            r_y       <= '0;
            r_adr     <= BASE_ADDR;
            r_bar_idx <= BAR_FIRST;
            r_bar_pos <= '0;
            r_burst   <= '0;
            busy      <= 1'b1;
            wb_cyc_o  <= 1'b1;
            wb_we_o   <= 1'b1;
            r_state   <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          wb_adr_o <= r_adr;
          wb_dat_o <= w_word;
          wb_sel_o <= '1;
          wb_stb_o <= 1'b1;
          r_state  <= ST_BURST;
        end

        ST_BURST: begin
          if (!wb_stb_o) begin
            // Bubble after an ack: present the next word from the updated raster position.
            wb_adr_o <= r_adr;
            wb_dat_o <= w_word;
            wb_sel_o <= '1;
            wb_stb_o <= 1'b1;
          end else if (wb_ack_i) begin
            wb_stb_o <= 1'b0;
            wb_sel_o <= '0;
            r_adr    <= r_adr + ADR_STEP;
            if (r_x == X_LAST) begin
              r_x       <= '0;
              r_y       <= r_y + Y_W'(1);
              r_bar_idx <= BAR_FIRST;
              r_bar_pos <= '0;
            end else begin
              r_x                    <= r_x + X_STEP;
              {r_bar_idx, r_bar_pos} <= w_bar_adv;
            end
            if (w_last) begin
              // busy drops together with the frame_done pulse unless another frame follows.
              wb_cyc_o   <= 1'b0;
              wb_we_o    <= 1'b0;
              frame_done <= 1'b1;
              busy       <= continuous;
              r_burst    <= '0;
              r_state    <= ST_DONE;
            end else if (r_burst == BURST_LAST) begin
              wb_cyc_o <= 1'b0;
              wb_we_o  <= 1'b0;
              r_burst  <= '0;
              r_yield  <= '0;
              r_state  <= ST_YIELD;
            end else begin
              r_burst <= r_burst + BC_W'(1);
            end
          end
        end

        ST_YIELD: begin
          if (r_yield == YIELD_LAST) begin
            wb_cyc_o <= 1'b1;
            wb_we_o  <= 1'b1;
            r_state  <= ST_LOAD;
          end else begin
            r_yield <= r_yield + YC_W'(1);
          end
        end

        ST_DONE: begin
          if (busy) begin
            r_mode    <= mode;
            r_fill    <= fill_color;
            r_x       <= '0;
            r_y       <= '0;
            r_adr     <= BASE_ADDR;
            r_bar_idx <= BAR_FIRST;
            r_bar_pos <= '0;
            r_burst   <= '0;
            wb_cyc_o  <= 1'b1;
            wb_we_o   <= 1'b1;
            r_state   <= ST_LOAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mire_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mire_gen
//  Purpose  : Directed self-checking bench for mire_gen: a 16-bit instance
//             (grid, checker, continuous fill, reset) and a 32-bit instance
//             (colour bars), both on a 32x4 raster.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mire_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ack_always;

  logic        a_start, a_cont, a_busy, a_fd, a_cyc, a_stb, a_we, a_ack;
  logic [1:0]  a_mode, a_sel;
  logic [15:0] a_fill, a_dat;
  logic [31:0] a_adr;

  logic        b_start, b_cont, b_busy, b_fd, b_cyc, b_stb, b_we, b_ack;
  logic [1:0]  b_mode;
  logic [3:0]  b_sel;
  logic [15:0] b_fill;
  logic [31:0] b_adr, b_dat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mire_gen #(
    .vga_HDISP(32), .vga_VDISP(4), .DATA_W(16), .ADR_W(32), .BASE_ADDR(32'h0),
    .GRID_LOG2(2), .BURST_LEN(8), .YIELD_CYC(4)
  ) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(a_start), .continuous(a_cont), .mode(a_mode),
    .fill_color(a_fill), .busy(a_busy), .frame_done(a_fd), .wb_cyc_o(a_cyc),
    .wb_stb_o(a_stb), .wb_we_o(a_we), .wb_sel_o(a_sel), .wb_adr_o(a_adr),
    .wb_dat_o(a_dat), .wb_ack_i(a_ack)
  );

  mire_gen #(
    .vga_HDISP(32), .vga_VDISP(4), .DATA_W(32), .ADR_W(32), .BASE_ADDR(32'h0),
    .GRID_LOG2(2), .BURST_LEN(8), .YIELD_CYC(4)
  ) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .continuous(b_cont), .mode(b_mode),
    .fill_color(b_fill), .busy(b_busy), .frame_done(b_fd), .wb_cyc_o(b_cyc),
    .wb_stb_o(b_stb), .wb_we_o(b_we), .wb_sel_o(b_sel), .wb_adr_o(b_adr),
    .wb_dat_o(b_dat), .wb_ack_i(b_ack)
  );

  // Slave model: either ack held high permanently, or ack after 3 wait cycles.
  int a_wcnt = 0;
  always @(posedge clk) begin
    if (!a_stb || a_ack) a_wcnt <= 0;
    else                 a_wcnt <= a_wcnt + 1;
  end
  assign a_ack = ack_always | (a_stb & (a_wcnt == 3));
  assign b_ack = ack_always;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference colour for a 32-pixel-wide raster, grid pitch 4, bar width 4.
  function automatic logic [15:0] model_pix(input int m, input logic [15:0] f, input int x, input int y);
    case (m)
      0: return ((x % 4 == 0) || (y % 4 == 0)) ? 16'hFFFF : 16'h0000;
      1: begin
        case (x / 4)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2: return ((((x / 4) ^ (y / 4)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: return f;
    endcase
  endfunction

  // Scoreboard state for both instances.
  int          exp_mode_a = 0, exp_mode_b = 0;
  logic [15:0] exp_fill_a = 16'h0, exp_fill_b = 16'h0;
  int          a_k = 0, a_writes = 0, a_fds = 0, a_yields = 0, a_low = 0;
  int          b_k = 0, b_writes = 0, b_fds = 0;
  logic [15:0] a_mem [128];
  logic [31:0] a_adr_mem [128];
  logic [31:0] b_mem [64];
  logic [31:0] b_adr_mem [64];
  logic        a_p_stb = 1'b0, a_p_ack = 1'b0;
  logic [31:0] a_p_adr = '0;
  logic [15:0] a_p_dat = '0;
  logic [1:0]  a_p_sel = '0;

  // 16-bit monitor: every accepted write, hold stability, yield length.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_stb && a_ack) begin
        a_mem[a_k]     = a_dat;
        a_adr_mem[a_k] = a_adr;
        chk("a_write_adr", 64'(a_adr), 64'(a_k * 2));
        chk("a_write_dat", 64'(a_dat), 64'(model_pix(exp_mode_a, exp_fill_a, a_k % 32, a_k / 32)));
        chk("a_write_sel", 64'(a_sel), 64'd3);
        chk("a_write_we", 64'(a_we), 64'd1);
        a_writes++;
        a_k = (a_k == 127) ? 0 : a_k + 1;
      end
      if (a_stb && a_p_stb && !a_p_ack) begin
        chk("a_hold_adr", 64'(a_adr), 64'(a_p_adr));
        chk("a_hold_dat", 64'(a_dat), 64'(a_p_dat));
        chk("a_hold_sel", 64'(a_sel), 64'(a_p_sel));
      end
      if (!a_busy) a_low = 0;
      else if (!a_cyc && !a_fd) a_low++;
      else if (a_cyc && a_low != 0) begin
        chk("a_yield_len", 64'(a_low), 64'd4);
        a_yields++;
        a_low = 0;
      end
      if (a_fd) a_fds++;
    end
    a_p_stb = a_stb; a_p_ack = a_ack; a_p_adr = a_adr; a_p_dat = a_dat; a_p_sel = a_sel;
  end

  // 32-bit monitor: two independently coloured pixels per word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_stb && b_ack) begin
        b_mem[b_k]     = b_dat;
        b_adr_mem[b_k] = b_adr;
        chk("b_write_adr", 64'(b_adr), 64'(b_k * 4));
        chk("b_write_dat", 64'(b_dat),
            64'({model_pix(exp_mode_b, exp_fill_b, (2 * b_k) % 32 + 1, (2 * b_k) / 32),
                 model_pix(exp_mode_b, exp_fill_b, (2 * b_k) % 32, (2 * b_k) / 32)}));
        chk("b_write_sel", 64'(b_sel), 64'hF);
        b_writes++;
        b_k = (b_k == 63) ? 0 : b_k + 1;
      end
      if (b_fd) b_fds++;
    end
  end

  task automatic pulse_a();
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
  endtask

  task automatic wait_fd_a(input int budget);
    int n = 0;
    while (a_fd !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    chk("a_frame_done_seen", 64'(a_fd), 64'd1);
  endtask

  task automatic wait_a_k(input int k, input int budget);
    int n = 0;
    while (a_k < k && n < budget) begin @(negedge clk); n++; end
    chk("a_progress_reached", 64'(a_k >= k), 64'd1);
  endtask

  logic [31:0] bar_exp [8];
  int w0, f0, y0, n;

  initial begin
    rst_n = 1'b0; ack_always = 1'b1;
    a_start = 0; a_cont = 0; a_mode = 0; a_fill = 16'h0;
    b_start = 0; b_cont = 0; b_mode = 0; b_fill = 16'h0;
    bar_exp[0] = 32'hFFFFFFFF; bar_exp[1] = 32'hFFE0FFE0; bar_exp[2] = 32'h07FF07FF;
    bar_exp[3] = 32'h07E007E0; bar_exp[4] = 32'hF81FF81F; bar_exp[5] = 32'hF800F800;
    bar_exp[6] = 32'h001F001F; bar_exp[7] = 32'h00000000;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cyc", 64'(a_cyc), 64'd0);
    chk("rst_stb", 64'(a_stb), 64'd0);
    chk("rst_we", 64'(a_we), 64'd0);
    chk("rst_sel", 64'(a_sel), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_fd", 64'(a_fd), 64'd0);
    chk("rst_adr", 64'(a_adr), 64'd0);
    chk("rst_dat", 64'(a_dat), 64'd0);
    chk("rst_b_cyc", 64'(b_cyc), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ack_ignored_cyc", 64'(a_cyc), 64'd0);

    // Grid, ack always high, fair-play bursts of 8
    a_mode = 2'd0; exp_mode_a = 0;
    w0 = a_writes; f0 = a_fds; y0 = a_yields;
    pulse_a();
    chk("grid_busy_after_start", 64'(a_busy), 64'd1);
    wait_fd_a(3000);
    chk("grid_busy_at_done", 64'(a_busy), 64'd0);
    @(negedge clk);
    chk("grid_idle_cyc", 64'(a_cyc), 64'd0);
    chk("grid_writes", 64'(a_writes - w0), 64'd128);
    chk("grid_yields", 64'(a_yields - y0), 64'd15);
    chk("grid_done_pulses", 64'(a_fds - f0), 64'd1);
    chk("grid_pix_0_1", 64'(a_mem[32]), 64'hFFFF);
    chk("grid_pix_1_1", 64'(a_mem[33]), 64'h0000);
    chk("grid_pix_4_1", 64'(a_mem[36]), 64'hFFFF);
    chk("grid_adr_first", 64'(a_adr_mem[0]), 64'h0);
    chk("grid_adr_last", 64'(a_adr_mem[127]), 64'hFE);

    // Checker with 3 wait states; a start pulse and mode change mid-frame are ignored
    ack_always = 1'b0; a_mode = 2'd2; exp_mode_a = 2;
    w0 = a_writes; f0 = a_fds;
    pulse_a();
    a_mode = 2'd1;
    wait_a_k(10, 2000);
    pulse_a();
    wait_fd_a(5000);
    @(negedge clk);
    chk("wait_writes", 64'(a_writes - w0), 64'd128);
    chk("wait_done_pulses", 64'(a_fds - f0), 64'd1);
    chk("chk_pix_3_0", 64'(a_mem[3]), 64'h0000);
    chk("chk_pix_4_0", 64'(a_mem[4]), 64'hFFFF);
    chk("chk_pix_8_0", 64'(a_mem[8]), 64'h0000);
    chk("chk_pix_12_0", 64'(a_mem[12]), 64'hFFFF);
    ack_always = 1'b1;

    // Colour bars on the 32-bit instance
    b_mode = 2'd1; exp_mode_b = 1;
    w0 = b_writes; f0 = b_fds;
    b_start = 1'b1; @(negedge clk); b_start = 1'b0;
    n = 0;
    while (b_fd !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    chk("bars_frame_done_seen", 64'(b_fd), 64'd1);
    @(negedge clk);
    chk("bars_writes", 64'(b_writes - w0), 64'd64);
    chk("bars_done_pulses", 64'(b_fds - f0), 64'd1);
    chk("bars_busy_end", 64'(b_busy), 64'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("bars_word%0d", 2 * i), 64'(b_mem[2 * i]), 64'(bar_exp[i]));
    chk("bars_word1", 64'(b_mem[1]), 64'hFFFFFFFF);
    chk("bars_adr_1", 64'(b_adr_mem[1]), 64'h4);
    chk("bars_adr_last", 64'(b_adr_mem[63]), 64'hFC);

    // Continuous solid fill; colour change takes effect only at the next frame
    a_mode = 2'd3; a_fill = 16'hF800; a_cont = 1'b1;
    exp_mode_a = 3; exp_fill_a = 16'hF800;
    w0 = a_writes; f0 = a_fds;
    pulse_a();
    wait_a_k(40, 2000);
    a_fill = 16'h001F;
    wait_fd_a(3000);
    exp_fill_a = 16'h001F;
    chk("cont_busy_at_done1", 64'(a_busy), 64'd1);
    chk("cont_f1_first", 64'(a_mem[0]), 64'hF800);
    chk("cont_f1_last", 64'(a_mem[127]), 64'hF800);
    a_cont = 1'b0;
    @(negedge clk);
    chk("cont_busy_after_done1", 64'(a_busy), 64'd1);
    chk("cont_cyc_after_done1", 64'(a_cyc), 64'd1);
    wait_fd_a(3000);
    chk("cont_busy_at_done2", 64'(a_busy), 64'd0);
    @(negedge clk);
    chk("cont_writes", 64'(a_writes - w0), 64'd256);
    chk("cont_done_pulses", 64'(a_fds - f0), 64'd2);
    chk("cont_f2_first", 64'(a_mem[0]), 64'h001F);
    chk("cont_f2_last", 64'(a_mem[127]), 64'h001F);

    // Reset mid-frame
    a_mode = 2'd0; exp_mode_a = 0;
    pulse_a();
    wait_a_k(50, 2000);
    f0 = a_fds;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cyc", 64'(a_cyc), 64'd0);
    chk("midrst_stb", 64'(a_stb), 64'd0);
    chk("midrst_busy", 64'(a_busy), 64'd0);
    chk("midrst_adr", 64'(a_adr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_k = 0;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", 64'(a_fds - f0), 64'd0);
    chk("midrst_stays_idle", 64'(a_cyc), 64'd0);
    w0 = a_writes; f0 = a_fds;
    pulse_a();
    wait_fd_a(3000);
    @(negedge clk);
    chk("restart_writes", 64'(a_writes - w0), 64'd128);
    chk("restart_adr_first", 64'(a_adr_mem[0]), 64'h0);
    chk("restart_done_pulses", 64'(a_fds - f0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mire_gen.md
Name: mire_gen

Overview:
- Parametrised Wishbone-master test-pattern generator.
- Writes a complete HDISP×VDISP RGB565 frame into the SDRAM framebuffer through the shared Wishbone bus.
- Compared with the first-generation mire, it adds:
  - a real ack handshake and byte-address generation;
  - four selectable patterns;
  - 16- or 32-bit data words;
  - configurable burst/yield fair-play;
  - single-shot or continuous operation with frame-done reporting.

Parameters:
- vga_HDISP, 640, pixels per line (must be even when DATA_W=32)
- vga_VDISP, 480, lines per frame
- DATA_W, 16, bus data width; 16 or 32 only (1 or 2 pixels per word)
- ADR_W, 32, Wishbone byte-address width
- BASE_ADDR, 0, byte address of pixel (0,0)
- GRID_LOG2, 4, grid/checker pitch = 2^GRID_LOG2 pixels
- BURST_LEN, 64, acked writes per bus tenure before yielding
- YIELD_CYC, 4, idle cycles (cyc=0) between bursts; ≥1

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- continuous  in  1  1 = restart automatically after each frame
- mode  in  2  0 grid, 1 colour bars, 2 checker, 3 solid
- fill_color  in  16  RGB565 colour for mode 3
- busy  out  1  high from accepted start until final frame ends
- frame_done  out  1  one-cycle pulse after last pixel acked
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  always 1 while cyc=1, else 0
- wb_sel_o  out  DATA_W/8  all ones while stb=1, else 0
- wb_adr_o  out  ADR_W  byte address
- wb_dat_o  out  DATA_W  pixel data
- wb_ack_i  in  1  slave acknowledge

Behaviour:
- **Reset (rst_n=0, async):**
  - State IDLE.
  - Outputs cleared: cyc, stb, we, sel, busy, frame_done, adr, dat.
  - Counters x, y and burst count cleared.
- **FSM states: IDLE, LOAD, BURST, YIELD, DONE.**
- **IDLE:**
  - On start=1: latch mode and fill_color into shadow registers, clear x/y, set busy=1, go to LOAD.
  - start is ignored in every other state.
- **LOAD (1 cycle):**
  - Compute wb_adr_o and wb_dat_o for the current (x,y), registered.
  - Then go to BURST.
- **BURST:**
  - cyc=stb=1.
  - adr/dat/sel are held stable while stb=1 and ack=0.
  - On ack:
    - x += PPW, where PPW = DATA_W/16.
    - At x = HDISP-PPW: x = 0 and y += 1.
    - Burst count += 1.
    - The next address/data are presented in the cycle after ack (1-cycle bubble with stb=0, cyc held 1), except where the rules below apply.
  - On the ack of the pixel at (HDISP-PPW, VDISP-1): go to DONE (takes priority over burst end).
  - Else when burst count reaches BURST_LEN: go to YIELD.
- **YIELD:**
  - cyc=stb=0 for exactly YIELD_CYC cycles, burst count cleared.
  - Then go to LOAD.
- **DONE (1 cycle):**
  - frame_done=1, cyc=stb=0.
  - If continuous=1: re-latch mode/fill_color, clear x/y, go to LOAD; busy stays 1.
  - Else: busy=0, go to IDLE.
- **Address:**
  - wb_adr_o = BASE_ADDR + (y*HDISP + x)*2.
  - Maintained incrementally: +DATA_W/8 per ack, reset to BASE_ADDR at frame start.
  - No multiplier.
- **Pixel colour at (x,y):**
  - Mode 0: FFFF if x[GRID_LOG2-1:0]==0 or y[GRID_LOG2-1:0]==0, else 0000.
  - Mode 1: eight vertical bars of width HDISP/8 (integer), left to right FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Bar index is tracked by a counter, not by division; pixels past 8×(HDISP/8) use bar 7.
  - Mode 2: FFFF if x[GRID_LOG2]^y[GRID_LOG2], else 0000.
  - Mode 3: latched fill_color.
- **DATA_W=32:** dat[15:0] = pixel x, dat[31:16] = pixel x+1 (each coloured independently).
- **Mid-frame changes:** mode/fill_color changes are ignored until the next frame start.
- **Ack outside stb:** ack while stb=0 is ignored.
- **Reset mid-frame:** immediate return to IDLE with all outputs cleared; no frame_done.

Test Plan:
- **Grid:** HDISP=32, VDISP=4, DATA_W=16, GRID_LOG2=2, mode 0, ack always 1, start pulse -> 128 acked writes; adr 0x0,0x2,…,0xFE; dat at (0,1)=FFFF, (1,1)=0000, (4,1)=FFFF; one frame_done; busy falls in the same cycle.
- **Fair-play:** BURST_LEN=8, YIELD_CYC=4 -> cyc drops after every 8th ack for exactly 4 cycles; 16 bursts total; no write lost or duplicated.
- **Wait states:** ack delayed 3 cycles per transfer -> adr/dat/sel stable throughout; x advances only on ack.
- **Colour bars, 32-bit:** DATA_W=32, mode 1, HDISP=32 -> 64 writes; line-0 words = FFFFFFFF, FFE0FFE0, …, 00000000; adr step 4.
- **Continuous mode:** continuous=1, mode 3, fill_color=F800; fill_color changed to 001F mid-frame -> frame 1 all F800; frame 2 all 001F; frame_done pulses twice; busy stays 1.
- **Reset mid-frame:** rst_n=0 during transfer 50 -> cyc/stb/busy=0 immediately, no frame_done; a subsequent start restarts at BASE_ADDR.
